// File: rtl/serial_frame_pkg.sv
// Shared types and sizing for the 5-bit serial frame receiver.
package serial_frame_pkg;

  localparam int unsigned DEF_DATA_W    = 5;
  localparam int unsigned DEF_PARITY_EN = 1;
  localparam int unsigned FRAME_LEN     = 1 + DEF_DATA_W + DEF_PARITY_EN + 1;
  localparam int unsigned CNT_W         = $clog2(DEF_DATA_W);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    DATA      = 3'd1,
    PARITY    = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } state_t;

  // Counter width for an arbitrary word size, never below one bit.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/serial_frame_out_buf.sv
// Output holding register with valid/ready handshake and overrun detection.
module serial_frame_out_buf
  import serial_frame_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] din,
  input  logic              perr_in,
  input  logic              ready,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              parity_err,
  output logic              overrun
);

  logic accept_c;
  logic take_c;

  // A new word may enter when the slot is empty or is being drained this edge.
  assign accept_c = data_valid && ready;
  assign take_c   = load && (!data_valid || ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= load && data_valid && !ready;
      if (take_c) begin
        data_out   <= din;
        parity_err <= perr_in;
        data_valid <= 1'b1;
      end else if (accept_c) begin
        data_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/serial_frame_rx_5bit.sv
// Serial frame receiver: start detect, LSB-first data, even parity, stop check.
module serial_frame_rx_5bit
  import serial_frame_pkg::*;
#(
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned PARITY_EN = DEF_PARITY_EN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              si,
  input  logic              en,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  input  logic              data_ready,
  output logic              parity_err,
  output logic              frame_err,
  output logic              overrun
);

  localparam int unsigned CW = cnt_width(DATA_W);

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              par_q, par_d;
  logic              frame_err_d;
  logic              load_c;
  logic              perr_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      shreg_q   <= '0;
      par_q     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shreg_q   <= shreg_d;
      par_q     <= par_d;
      frame_err <= frame_err_d;
    end
  end

  // Next-state logic; every transition waits for an enabled sample edge.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shreg_d     = shreg_q;
    par_d       = par_q;
    frame_err_d = 1'b0;
    load_c      = 1'b0;
    if (en) begin
      case (state_q)
        IDLE: begin
          if (!si) begin
            state_d = DATA;
            cnt_d   = '0;
            par_d   = 1'b0;
          end
        end
        DATA: begin
          shreg_d[cnt_q] = si;
          par_d          = par_q ^ si;
          if (cnt_q == CW'(DATA_W - 1)) begin
            cnt_d   = '0;
            state_d = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        PARITY: begin
          par_d   = par_q ^ si;
          state_d = STOP;
        end
        STOP: begin
          if (si) begin
            load_c  = 1'b1;
            state_d = IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = WAIT_IDLE;
          end
        end
        WAIT_IDLE: begin
          if (si) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Accumulated XOR over data and parity bit is nonzero on an even-parity error.
  assign perr_c = (PARITY_EN != 0) ? par_q : 1'b0;

  serial_frame_out_buf #(
    .DATA_W (DATA_W)
  ) u_out_buf (
    .clk        (clk),
    .rst        (rst),
    .load       (load_c),
    .din        (shreg_q),
    .perr_in    (perr_c),
    .ready      (data_ready),
    .data_out   (data_out),
    .data_valid (data_valid),
    .parity_err (parity_err),
    .overrun    (overrun)
  );

endmodule

// File: tb/tb_serial_frame_rx_5bit.sv
// Scoreboard bench for serial_frame_rx_5bit with a frame-level reference model.
module tb_serial_frame_rx_5bit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       si = 1'b1;
  logic       en = 1'b0;
  logic       data_ready = 1'b0;
  logic [4:0] data_out;
  logic       data_valid;
  logic       parity_err;
  logic       frame_err;
  logic       overrun;

  serial_frame_rx_5bit #(.DATA_W(5), .PARITY_EN(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .si         (si),
    .en         (en),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] w;
    logic       p;
  } exp_t;

  exp_t       q[$];
  int         ntests = 0;
  int         nfail  = 0;
  bit         held   = 1'b0;
  int         rmode  = 0;     // 0: ready high, 1: random, 2: ready only on stop edges if rstop
  bit         rstop  = 1'b0;
  bit         gate   = 1'b0;
  logic [4:0] cur_word;
  logic       cur_perr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock edge with the given line/enable; model updates with the edge outcome.
  task automatic tick(input logic s, input logic e, input bit stop_edge);
    logic r;
    bit good, bad, ov;
    si = s;
    en = e;
    case (rmode)
      0:       data_ready = 1'b1;
      1:       data_ready = 1'($urandom_range(0, 1));
      default: data_ready = stop_edge && e && rstop;
    endcase
    r = data_ready;
    @(posedge clk);
    good = stop_edge && e && s;
    bad  = stop_edge && e && !s;
    ov   = 1'b0;
    if (good) begin
      if (!held || r) begin
        q.push_back('{cur_word, cur_perr});
        held = 1'b1;
      end else begin
        ov = 1'b1;
      end
    end else if (held && r) begin
      held = 1'b0;
    end
    #1;
    chk("frame_err", 32'(frame_err), 32'(bad));
    chk("overrun", 32'(overrun), 32'(ov));
  endtask

  task automatic do_bit(input logic s, input bit stop_edge);
    if (gate) tick(1'($urandom_range(0, 1)), 1'b0, 1'b0);
    tick(s, 1'b1, stop_edge);
  endtask

  task automatic send_frame(input logic [4:0] w, input bit inj, input logic stop, input int lows);
    cur_word = w;
    cur_perr = inj;
    do_bit(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) do_bit(w[i], 1'b0);
    do_bit((^w) ^ inj, 1'b0);
    do_bit(stop, 1'b1);
    if (!stop) begin
      repeat (lows) do_bit(1'b0, 1'b0);
      do_bit(1'b1, 1'b0);
    end
  endtask

  // Monitor: valid must track the model; each accepted word is popped and compared.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      chk("data_valid", 32'(data_valid), 32'(held));
      if (data_valid && data_ready) begin
        if (q.size() == 0) begin
          ntests++;
          nfail++;
          $display("FAIL unexpected_word: got %0h expected none at %0t", data_out, $time);
        end else begin
          e = q.pop_front();
          chk("data_out", 32'(data_out), 32'(e.w));
          chk("parity_err", 32'(parity_err), 32'(e.p));
        end
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_data_out", 32'(data_out), 32'd0);
    chk("rst_valid", 32'(data_valid), 32'd0);
    chk("rst_perr", 32'(parity_err), 32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    rst = 1'b0;
    tick(1'b1, 1'b1, 1'b0);

    // Good frame and parity error, continuous enable, ready high
    rmode = 0;
    send_frame(5'b10110, 1'b0, 1'b1, 0);
    tick(1'b1, 1'b1, 1'b0);
    send_frame(5'b10110, 1'b1, 1'b1, 0);
    tick(1'b1, 1'b1, 1'b0);

    // Frame error with line held low, then recovery
    send_frame(5'b10110, 1'b0, 1'b0, 3);
    send_frame(5'b00001, 1'b0, 1'b1, 0);
    tick(1'b1, 1'b1, 1'b0);

    // Overrun: consumer stalled across two back-to-back frames
    rmode = 2;
    rstop = 1'b0;
    send_frame(5'b11111, 1'b0, 1'b1, 0);
    send_frame(5'b00011, 1'b0, 1'b1, 0);
    tick(1'b1, 1'b1, 1'b0);
    rmode = 0;
    repeat (2) tick(1'b1, 1'b1, 1'b0);

    // Accept and load on the same edge
    rmode = 2;
    rstop = 1'b1;
    send_frame(5'b01010, 1'b0, 1'b1, 0);
    send_frame(5'b10101, 1'b1, 1'b1, 0);
    rmode = 0;
    repeat (2) tick(1'b1, 1'b1, 1'b0);

    // Enable toggling every cycle
    gate = 1'b1;
    send_frame(5'b10110, 1'b0, 1'b1, 0);
    send_frame(5'b01101, 1'b0, 1'b1, 0);
    gate = 1'b0;
    repeat (2) tick(1'b1, 1'b1, 1'b0);

    // Reset mid-frame with a held word present
    rmode = 2;
    rstop = 1'b0;
    send_frame(5'b11001, 1'b0, 1'b1, 0);
    do_bit(1'b0, 1'b0);
    do_bit(1'b1, 1'b0);
    do_bit(1'b0, 1'b0);
    do_bit(1'b1, 1'b0);
    #2;
    rst = 1'b1;
    held = 1'b0;
    q.delete();
    #1;
    chk("mid_rst_data_out", 32'(data_out), 32'd0);
    chk("mid_rst_valid", 32'(data_valid), 32'd0);
    chk("mid_rst_perr", 32'(parity_err), 32'd0);
    chk("mid_rst_frame_err", 32'(frame_err), 32'd0);
    chk("mid_rst_overrun", 32'(overrun), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    rmode = 0;
    send_frame(5'b01101, 1'b0, 1'b1, 0);
    repeat (2) tick(1'b1, 1'b1, 1'b0);

    // Randomized frames, errors, gaps, enable gating and consumer stalls
    rmode = 1;
    for (int n = 0; n < 150; n++) begin
      gate = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 2)) do_bit(1'b1, 1'b0);
      send_frame(5'($urandom), ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 9) != 0), $urandom_range(0, 3));
    end
    gate = 1'b0;
    rmode = 0;
    repeat (3) tick(1'b1, 1'b1, 1'b0);
    chk("queue_drained", 32'(q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/serial_frame_rx_5bit.md
# serial_frame_rx_5bit

Serial frame receiver for the 5-bit datapath. It sits directly downstream of the 5-bit universal shift register and takes that register's serial output as its line input. It detects a start bit, assembles 5 data bits LSB-first, checks even parity and the stop bit, and presents each word on a valid/ready parallel port with error flags.

## Interface
Parameters:
- DATA_W, 5, data bits per frame
- PARITY_EN, 1, 1 = even parity bit present between data and stop; 0 = no parity bit

Ports:
- clk  input  1  clock; all state changes on rising edge
- rst  input  1  asynchronous, active-high reset
- si  input  1  serial line (shift-register serial out); idle = 1
- en  input  1  sample strobe; line sampled only on edges where en=1
- data_out  output  DATA_W  received word
- data_valid  output  1  data_out holds an unconsumed word
- data_ready  input  1  consumer accepts word when data_valid && data_ready
- parity_err  output  1  parity mismatch on the word in data_out; qualified by data_valid
- frame_err  output  1  one-cycle pulse: stop bit sampled 0
- overrun  output  1  one-cycle pulse: frame completed while the held word was not consumed; new word dropped

## Operation
- States: IDLE, DATA, PARITY, STOP, WAIT_IDLE. Transitions are evaluated only on en=1 edges; en=0 holds all state.
- IDLE: si=0 -> DATA, bit counter cleared. si=1 -> stay.
- DATA: shift si into the shift buffer at bit[cnt], LSB first; after DATA_W bits -> PARITY (PARITY_EN=1) else STOP.
- PARITY: capture the parity bit; error = XOR(data bits, parity bit) != 0 (even parity) -> STOP.
- STOP with si=1: frame good.
  - If !data_valid, or data_ready is high this cycle: load data_out and parity_err, set data_valid=1.
  - Otherwise pulse overrun; data_out and parity_err are unchanged.
  - Next state IDLE.
- STOP with si=0: pulse frame_err, discard the word, go to WAIT_IDLE.
- WAIT_IDLE: stay until si=1 sampled, then IDLE. A line stuck low never produces a word.
- Handshake: data_valid clears on the edge where data_valid && data_ready, unless the same edge loads a new word; in that case valid stays 1 and there is no overrun. data_out is stable while data_valid && !data_ready.
- Reset (asynchronous, any time, including mid-frame): state=IDLE, counter=0, data_out=0, data_valid=0, parity_err=0, frame_err=0, overrun=0. The partial frame is lost.

## Timing
- A frame occupies 1 + DATA_W + PARITY_EN + 1 enabled edges: 8 at the defaults.
- data_valid rises after the edge that samples the stop bit. There is no extra pipeline stage.
- A new start bit may be sampled on the enabled edge immediately after the stop edge, so back-to-back frames are supported.
- frame_err and overrun are high for exactly one clk cycle, on the cycle after the stop-sample edge, regardless of en.
- Outputs are registered; none depend combinationally on inputs.

## Structure
- Package serial_frame_pkg holds:
  - state enum (IDLE, DATA, PARITY, STOP, WAIT_IDLE)
  - DATA_W default
  - FRAME_LEN = 1 + DATA_W + PARITY_EN + 1
  - bit counter width $clog2(DATA_W)
- Sub-module serial_frame_out_buf implements the output holding register and handshake (load, valid, ready, overrun).
- The top level holds the FSM, shift buffer, counter and parity accumulator.

## Test plan
- Good frame, en=1 continuous, data_ready=1: si = 0,0,1,1,0,1,1,1 (start, word 5'b10110 LSB first, parity 1, stop) -> data_valid=1 after edge 8, data_out=5'b10110, parity_err=0.
- Parity error: same frame with parity bit 0 -> data_out=5'b10110, data_valid=1, parity_err=1.
- Frame error then recovery:
  - Stop bit 0, line held 0 for 3 more cycles -> frame_err pulses once, data_valid stays 0, no start is detected while low.
  - Then si=1 followed by a good frame carrying 5'b00001 -> valid word 5'b00001.
- Overrun:
  - data_ready=0, two back-to-back good frames carrying 5'b11111 (parity 1) and 5'b00011 (parity 0) -> data_out stays 5'b11111, overrun pulses at the second stop.
  - Raising ready then clears valid.
- Simultaneous accept and load: data_ready pulsed on the second frame's stop edge -> data_valid stays 1, data_out becomes the second word, no overrun.
- en gating and reset:
  - en toggled 1/0 every cycle -> same words as the continuous case, taking 2x the cycles.
  - rst asserted after the 3rd data bit -> all outputs 0 immediately.
  - A following full frame decodes correctly.
